// File: rtl/fetch_pkg.sv
// Shared definitions for the instruction-fetch slice: state encoding,
// default geometry and the branch-offset sign-extension helper.
package fetch_pkg;

  localparam int          FETCH_ADDR_W      = 8;
  localparam logic [31:0] DEFAULT_HALT_WORD = 32'hFFFF_FFFF;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    HALT = 2'd2
  } fetch_state_t;

  // Callers truncate the 32-bit result to their own PC width (ADDR_W <= 32).
  function automatic logic [31:0] sext16(input logic [15:0] value);
    return {{16{value[15]}}, value};
  endfunction

endpackage

// File: rtl/branch_target_calc.sv
// Combinational BEQ-style target: branch PC + 1 + signed word offset,
// wrapped to the PC width. Also usable by the execute stage.
module branch_target_calc
  import fetch_pkg::*;
#(
  parameter int ADDR_W = FETCH_ADDR_W
) (
  input  logic [ADDR_W-1:0] i_branch_pc,
  input  logic [15:0]       i_branch_offset,
  output logic [ADDR_W-1:0] o_target
);

  assign o_target = ADDR_W'(32'(i_branch_pc) + 32'd1 + sext16(i_branch_offset));

endmodule

// File: rtl/fetch_sequencer.sv
// Instruction fetch sequencer: owns the PC, registers the memory word and
// hands it to decode over valid/ready, with branch redirect and halt.
module fetch_sequencer
  import fetch_pkg::*;
#(
  parameter int                ADDR_W    = FETCH_ADDR_W,
  parameter logic [ADDR_W-1:0] RESET_PC  = '0,
  parameter logic [31:0]       HALT_WORD = DEFAULT_HALT_WORD,
  parameter int                CNT_W     = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  output logic [31:0]       mem_addr,
  input  logic [31:0]       mem_rdata,
  output logic [31:0]       if_instr,
  output logic [ADDR_W-1:0] if_pc,
  output logic              if_valid,
  input  logic              id_ready,
  input  logic              branch_taken,
  input  logic [ADDR_W-1:0] branch_pc,
  input  logic [15:0]       branch_offset,
  output logic              halted,
  output logic [1:0]        state_o,
  output logic [CNT_W-1:0]  fetch_count
);

  fetch_state_t      r_state;
  logic [ADDR_W-1:0] r_pc;
  logic [31:0]       r_if_instr;
  logic [ADDR_W-1:0] r_if_pc;
  logic              r_if_valid;
  logic              r_halted;
  logic [CNT_W-1:0]  r_count;

  fetch_state_t      w_state_nxt;
  logic [ADDR_W-1:0] w_pc_nxt;
  logic [31:0]       w_instr_nxt;
  logic [ADDR_W-1:0] w_ifpc_nxt;
  logic              w_valid_nxt;
  logic              w_halted_nxt;
  logic [ADDR_W-1:0] w_target;
  logic              w_adv;
  logic              w_accept;
  logic              w_count_en;

  branch_target_calc #(
    .ADDR_W(ADDR_W)
  ) u_target (
    .i_branch_pc    (branch_pc),
    .i_branch_offset(branch_offset),
    .o_target       (w_target)
  );

  assign w_adv    = !r_if_valid || id_ready;
  assign w_accept = r_if_valid && id_ready;
  // A redirect in RUN flushes the presented word, so that handshake is not counted.
  assign w_count_en = w_accept && !(branch_taken && (r_state == RUN)) &&
                      (r_count != {CNT_W{1'b1}});

  always_comb begin
    w_state_nxt  = r_state;
    w_pc_nxt     = r_pc;
    w_instr_nxt  = r_if_instr;
    w_ifpc_nxt   = r_if_pc;
    w_valid_nxt  = r_if_valid;
    w_halted_nxt = r_halted;
    case (r_state)
      IDLE: begin
        w_valid_nxt = 1'b0;
        if (branch_taken) begin
          w_pc_nxt = w_target;
        end else if (start) begin
          w_state_nxt = RUN;
        end
      end
      RUN: begin
        if (branch_taken) begin
          w_pc_nxt    = w_target;
          w_valid_nxt = 1'b0;
        end else if (w_adv && (mem_rdata == HALT_WORD)) begin
          w_valid_nxt  = 1'b0;
          w_state_nxt  = HALT;
          w_halted_nxt = 1'b1;
        end else if (w_adv) begin
          w_instr_nxt = mem_rdata;
          w_ifpc_nxt  = r_pc;
          w_valid_nxt = 1'b1;
          w_pc_nxt    = r_pc + ADDR_W'(1);
        end
      end
      HALT: begin
        // A word still on the interface may drain but is never refilled.
        if (w_accept) begin
          w_valid_nxt = 1'b0;
        end
      end
      default: begin
        w_state_nxt = IDLE;
        w_valid_nxt = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state    <= IDLE;
      r_pc       <= RESET_PC;
      r_if_instr <= '0;
      r_if_pc    <= '0;
      r_if_valid <= 1'b0;
      r_halted   <= 1'b0;
      r_count    <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_pc       <= w_pc_nxt;
      r_if_instr <= w_instr_nxt;
      r_if_pc    <= w_ifpc_nxt;
      r_if_valid <= w_valid_nxt;
      r_halted   <= w_halted_nxt;
      if (w_count_en) begin
        r_count <= r_count + CNT_W'(1);
      end
    end
  end

  assign mem_addr    = 32'(r_pc);
  assign if_instr    = r_if_instr;
  assign if_pc       = r_if_pc;
  assign if_valid    = r_if_valid;
  assign halted      = r_halted;
  assign state_o     = r_state;
  assign fetch_count = r_count;

endmodule
